// File: rtl/instruction_fetcher_if.sv
// Fetch-unit bus bundle: decoder issue port, memory request port and ROB redirect.
// master = fetcher side, slave = decoder/memory/ROB side.
interface instruction_fetcher_if;
    logic        Decoder_not_ready_accept;
    logic        update_instr_valid;
    logic [31:0] update_instr;
    logic [31:0] update_instr_pc;
    logic        update_instr_isjump;
    logic [31:0] update_instr_jump_wrong_to_pc;
    logic        IF_mem_req;
    logic [31:0] IF_mem_addr;
    logic        mem_IF_done;
    logic [31:0] mem_IF_data;
    logic        ROB_jump_wrong;
    logic [31:0] ROB_jump_wrong_pc;

    modport master (
        input  Decoder_not_ready_accept, mem_IF_done, mem_IF_data,
               ROB_jump_wrong, ROB_jump_wrong_pc,
        output update_instr_valid, update_instr, update_instr_pc,
               update_instr_isjump, update_instr_jump_wrong_to_pc,
               IF_mem_req, IF_mem_addr
    );

    modport slave (
        output Decoder_not_ready_accept, mem_IF_done, mem_IF_data,
               ROB_jump_wrong, ROB_jump_wrong_pc,
        input  update_instr_valid, update_instr, update_instr_pc,
               update_instr_isjump, update_instr_jump_wrong_to_pc,
               IF_mem_req, IF_mem_addr
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Single-outstanding instruction fetcher with static JAL/backward-branch prediction,
// an instruction FIFO feeding the decoder, and ROB-driven flush/redirect.
module instruction_fetcher #(
    parameter int          QUEUE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    instruction_fetcher_if.master        bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(QUEUE_DEPTH);
    localparam logic [6:0]       OP_JAL = 7'b1101111;
    localparam logic [6:0]       OP_BR  = 7'b1100011;

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t           state_reg, state_next;
    logic [31:0]      pc_reg, pc_next;
    logic             req_reg, req_next;
    logic [31:0]      addr_reg, addr_next;
    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             valid_reg;
    logic [31:0]      out_instr_reg, out_pc_reg, out_alt_reg;
    logic             out_jump_reg;

    logic [31:0] q_instr [QUEUE_DEPTH];
    logic [31:0] q_pc    [QUEUE_DEPTH];
    logic [31:0] q_alt   [QUEUE_DEPTH];
    logic        q_jump  [QUEUE_DEPTH];

    logic        flush, push, pop;
    logic [31:0] imm_j, imm_b, pc_plus4, pred_next, pred_alt;
    logic        pred_jump;
    logic [31:0] d;

    assign d = bus.mem_IF_data;

    // Static prediction on the returning word; pc_reg still holds its fetch address.
    always_comb begin
        imm_j     = {{12{d[31]}}, d[19:12], d[20], d[30:21], 1'b0};
        imm_b     = {{20{d[31]}}, d[7], d[30:25], d[11:8], 1'b0};
        pc_plus4  = pc_reg + 32'd4;
        pred_next = pc_plus4;
        pred_alt  = pc_plus4;
        pred_jump = 1'b0;
        if (d[6:0] == OP_JAL) begin
            pred_next = pc_reg + imm_j;
            pred_jump = 1'b1;
        end else if (d[6:0] == OP_BR) begin
            if (d[31]) begin
                pred_next = pc_reg + imm_b;
                pred_jump = 1'b1;
            end else begin
                pred_alt  = pc_reg + imm_b;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        req_next   = req_reg;
        addr_next  = addr_reg;
        push       = 1'b0;
        flush      = rdy && bus.ROB_jump_wrong;
        if (rdy) begin
            if (flush)
                pc_next = bus.ROB_jump_wrong_pc;
            unique case (state_reg)
                IDLE: begin
                    if (!flush && count_reg < FULL) begin
                        req_next   = 1'b1;
                        addr_next  = pc_reg;
                        state_next = BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_IF_done) begin
                        req_next   = 1'b0;
                        state_next = IDLE;
                        if (!flush) begin
                            push    = 1'b1;
                            pc_next = pred_next;
                        end
                    end else if (flush) begin
                        // Memory still owes us a word; keep the request up and drain it.
                        state_next = DROP;
                    end
                end
                DROP: begin
                    if (bus.mem_IF_done) begin
                        req_next   = 1'b0;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        pop = rdy && !flush && (count_reg != '0) && !bus.Decoder_not_ready_accept;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            req_reg       <= 1'b0;
            addr_reg      <= '0;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            valid_reg     <= 1'b0;
            out_instr_reg <= '0;
            out_pc_reg    <= '0;
            out_alt_reg   <= '0;
            out_jump_reg  <= 1'b0;
        end else if (rdy) begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            req_reg   <= req_next;
            addr_reg  <= addr_next;
            if (flush) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
                valid_reg <= 1'b0;
            end else begin
                if (push)
                    tail_reg <= tail_reg + 1'b1;
                if (pop) begin
                    head_reg      <= head_reg + 1'b1;
                    out_instr_reg <= q_instr[head_reg];
                    out_pc_reg    <= q_pc[head_reg];
                    out_alt_reg   <= q_alt[head_reg];
                    out_jump_reg  <= q_jump[head_reg];
                end
                count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
                valid_reg <= pop;
            end
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail_reg] <= d;
            q_pc[tail_reg]    <= pc_reg;
            q_alt[tail_reg]   <= pred_alt;
            q_jump[tail_reg]  <= pred_jump;
        end
    end

    assign bus.IF_mem_req                    = req_reg;
    assign bus.IF_mem_addr                   = addr_reg;
    assign bus.update_instr_valid            = valid_reg;
    assign bus.update_instr                  = out_instr_reg;
    assign bus.update_instr_pc               = out_pc_reg;
    assign bus.update_instr_isjump           = out_jump_reg;
    assign bus.update_instr_jump_wrong_to_pc = out_alt_reg;
endmodule
